// File: rtl/decode_execute_reg.sv
// D->E pipeline register: captures decoded operands/control, applies stall/flush/bubble,
// detects load-use hazards and forwards M/W results onto the E-stage operands.
`ifndef alu_valA_sel_valA
`define alu_valA_sel_valA 2'd0
`endif
`ifndef alu_valB_sel_valB
`define alu_valB_sel_valB 2'd0
`endif
`ifndef ALU_FUNC_ADD
`define ALU_FUNC_ADD 4'd0
`endif

module decode_execute_reg #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_i_valid,
  input  logic [XLEN-1:0]    dec_i_valA,
  input  logic [XLEN-1:0]    dec_i_valB,
  input  logic [XLEN-1:0]    dec_i_imm,
  input  logic [XLEN-1:0]    dec_i_pc,
  input  logic [XLEN-1:0]    dec_i_pre_pc,
  input  logic [RADDR_W-1:0] dec_i_rs1,
  input  logic [RADDR_W-1:0] dec_i_rs2,
  input  logic [RADDR_W-1:0] dec_i_rd,
  input  logic               dec_i_use_rs1,
  input  logic               dec_i_use_rs2,
  input  logic [1:0]         dec_i_alu_valA_sel,
  input  logic [1:0]         dec_i_alu_valB_sel,
  input  logic [3:0]         dec_i_alu_func_sel,
  input  logic               dec_i_alu_W_instr,
  input  logic               dec_i_need_jump,
  input  logic               dec_i_is_jalr,
  input  logic               dec_i_reg_wen,
  input  logic               dec_i_mem_read,
  input  logic               dec_i_mem_write,
  input  logic [RADDR_W-1:0] mem_i_rd,
  input  logic               mem_i_reg_wen,
  input  logic [XLEN-1:0]    mem_i_valE,
  input  logic [RADDR_W-1:0] wb_i_rd,
  input  logic               wb_i_reg_wen,
  input  logic [XLEN-1:0]    wb_i_valW,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [XLEN-1:0]    regE_o_valA,
  output logic [XLEN-1:0]    regE_o_valB,
  output logic [XLEN-1:0]    regE_o_imm,
  output logic [XLEN-1:0]    regE_o_pc,
  output logic [XLEN-1:0]    regE_o_pre_pc,
  output logic [RADDR_W-1:0] regE_o_rd,
  output logic [1:0]         regE_o_alu_valA_sel,
  output logic [1:0]         regE_o_alu_valB_sel,
  output logic [3:0]         regE_o_alu_func_sel,
  output logic               regE_o_alu_W_instr,
  output logic               regE_o_need_jump,
  output logic               regE_o_is_jalr,
  output logic               regE_o_reg_wen,
  output logic               regE_o_mem_read,
  output logic               regE_o_mem_write,
  output logic               regE_o_valid,
  output logic               hazard_o_load_use
);

  logic               valid_reg;
  logic [XLEN-1:0]    imm_reg, pc_reg, pre_pc_reg;
  logic [RADDR_W-1:0] rd_reg;
  logic [1:0]         vala_sel_reg, valb_sel_reg;
  logic [3:0]         func_reg;
  logic               w_instr_reg, need_jump_reg, is_jalr_reg;
  logic               reg_wen_reg, mem_read_reg, mem_write_reg;

  // Operand slot 0 is rs1/valA, slot 1 is rs2/valB.
  logic [XLEN-1:0]    dec_val [2];
  logic [RADDR_W-1:0] dec_rs  [2];
  logic               dec_use [2];
  logic [XLEN-1:0]    cap_val [2];
  logic [XLEN-1:0]    out_val [2];
  logic [XLEN-1:0]    val_reg [2];
  logic [RADDR_W-1:0] rs_reg  [2];
  logic               use_reg [2];
  logic               bubble_en;

  assign dec_val[0] = dec_i_valA;
  assign dec_val[1] = dec_i_valB;
  assign dec_rs[0]  = dec_i_rs1;
  assign dec_rs[1]  = dec_i_rs2;
  assign dec_use[0] = dec_i_use_rs1;
  assign dec_use[1] = dec_i_use_rs2;

  assign hazard_o_load_use = valid_reg && mem_read_reg && (rd_reg != '0) && dec_i_valid &&
                             ((dec_i_use_rs1 && dec_i_rs1 == rd_reg) ||
                              (dec_i_use_rs2 && dec_i_rs2 == rd_reg));

  assign bubble_en = flush_i || hazard_o_load_use;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic cap_bypass, fwd_mem, fwd_wb;
      // Register-file write-through: W writes in the same cycle decode reads.
      assign cap_bypass  = wb_i_reg_wen && (wb_i_rd != '0) && (wb_i_rd == dec_rs[gi]);
      assign cap_val[gi] = cap_bypass ? wb_i_valW : dec_val[gi];
      assign fwd_mem     = valid_reg && use_reg[gi] && mem_i_reg_wen &&
                           (mem_i_rd != '0) && (mem_i_rd == rs_reg[gi]);
      assign fwd_wb      = valid_reg && use_reg[gi] && wb_i_reg_wen &&
                           (wb_i_rd != '0) && (wb_i_rd == rs_reg[gi]);
      assign out_val[gi] = fwd_mem ? mem_i_valE : (fwd_wb ? wb_i_valW : val_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || (!stall_i && bubble_en)) begin
      valid_reg     <= 1'b0;
      imm_reg       <= '0;
      pc_reg        <= '0;
      pre_pc_reg    <= '0;
      rd_reg        <= '0;
      vala_sel_reg  <= `alu_valA_sel_valA;
      valb_sel_reg  <= `alu_valB_sel_valB;
      func_reg      <= `ALU_FUNC_ADD;
      w_instr_reg   <= 1'b0;
      need_jump_reg <= 1'b0;
      is_jalr_reg   <= 1'b0;
      reg_wen_reg   <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        val_reg[i] <= '0;
        rs_reg[i]  <= '0;
        use_reg[i] <= 1'b0;
      end
    end else if (!stall_i) begin
      valid_reg     <= dec_i_valid;
      imm_reg       <= dec_i_imm;
      pc_reg        <= dec_i_pc;
      pre_pc_reg    <= dec_i_pre_pc;
      rd_reg        <= dec_i_rd;
      vala_sel_reg  <= dec_i_alu_valA_sel;
      valb_sel_reg  <= dec_i_alu_valB_sel;
      func_reg      <= dec_i_alu_func_sel;
      w_instr_reg   <= dec_i_alu_W_instr;
      need_jump_reg <= dec_i_need_jump;
      is_jalr_reg   <= dec_i_is_jalr;
      reg_wen_reg   <= dec_i_reg_wen;
      mem_read_reg  <= dec_i_mem_read;
      mem_write_reg <= dec_i_mem_write;
      for (int i = 0; i < 2; i++) begin
        val_reg[i] <= cap_val[i];
        rs_reg[i]  <= dec_rs[i];
        use_reg[i] <= dec_use[i];
      end
    end
  end

  assign regE_o_valA         = out_val[0];
  assign regE_o_valB         = out_val[1];
  assign regE_o_imm          = imm_reg;
  assign regE_o_pc           = pc_reg;
  assign regE_o_pre_pc       = pre_pc_reg;
  assign regE_o_rd           = rd_reg;
  assign regE_o_alu_valA_sel = vala_sel_reg;
  assign regE_o_alu_valB_sel = valb_sel_reg;
  assign regE_o_alu_func_sel = func_reg;
  assign regE_o_alu_W_instr  = w_instr_reg;
  assign regE_o_need_jump    = need_jump_reg;
  assign regE_o_is_jalr      = is_jalr_reg;
  assign regE_o_reg_wen      = reg_wen_reg;
  assign regE_o_mem_read     = mem_read_reg;
  assign regE_o_mem_write    = mem_write_reg;
  assign regE_o_valid        = valid_reg;

endmodule
